fusion_trace_buffer: RTL and testbench

//  On-chip, synthesizable trace capture for the fused RV32I pipeline; successor to the bench-side CSV logger.

---
 rtl/fusion_trace_buffer.sv | 139 +++++++++++++
 tb/tb_fusion_trace_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fusion_trace_buffer.sv
// Purpose: on-chip trace capture of the fused-pipeline decode stream into a FWFT FIFO with arm/trigger/filter control.
// Latency: a record stored at edge N is visible on out_valid/out_data after edge N; counters update at the same edge.
// Backpressure: out_ready stalls the drain; a store into a full FIFO without a same-cycle pop is dropped and counted.
module fusion_trace_buffer #(
    parameter int PC_W     = 32,
    parameter int DEPTH    = 16,
    parameter int TS_W     = 16,
    parameter int CNT_W    = 16,
    parameter int CAPT_LEN = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trace_valid,
    input  logic [PC_W-1:0]           trace_pc,
    input  logic [31:0]               trace_instr,
    input  logic                      trace_fuse,
    input  logic [1:0]                trace_ftype,
    input  logic                      arm,
    input  logic                      trig_mode,
    input  logic [PC_W-1:0]           trig_pc,
    input  logic                      fused_only,
    input  logic                      abort,
    input  logic                      clear,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TS_W+PC_W+34:0]     out_data,
    output logic [4*CNT_W-1:0]        fuse_cnt,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic [1:0]                state
);
    localparam int AW  = $clog2(DEPTH);
    localparam int DW  = TS_W + PC_W + 35;
    localparam int CLW = (CAPT_LEN > 0) ? $clog2(CAPT_LEN + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_CAPT  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t          cur, nxt;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [TS_W-1:0] ts;
    logic [CLW-1:0]  capt_cnt;
    logic [CNT_W-1:0] cnt [4];

    logic trig_hit, store, empty, full, pop, push, drop, last_rec, count_en;
    logic [DW-1:0] record;

    // An abort in ARMED wins over a same-cycle trigger match, so that record is not taken.
    assign trig_hit = (cur == S_ARMED) && trace_valid && (trace_pc == trig_pc);
    assign store    = !clear && trace_valid && (!fused_only || trace_fuse) &&
                      ((cur == S_CAPT) || (trig_hit && !abort));
    assign last_rec = (CAPT_LEN != 0) && store && (int'(capt_cnt) == CAPT_LEN - 1);
    assign count_en = !clear && trace_valid && ((cur == S_ARMED) || (cur == S_CAPT));

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = !empty && out_ready;
    assign push   = store && (!full || pop);
    assign drop   = store && full && !pop;
    assign record = {ts, trace_pc, trace_instr, trace_fuse, trace_ftype};

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign state     = cur;

    for (genvar g = 0; g < 4; g++) begin : g_cnt_out
        assign fuse_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end

    // Next state: clear beats abort, abort beats arm, then capture-length stop, then trigger.
    always_comb begin
        nxt = cur;
        if (clear) begin
            nxt = S_IDLE;
        end else if (abort) begin
            nxt = (cur == S_IDLE) ? S_IDLE : S_DONE;
        end else if (arm && (cur == S_IDLE || cur == S_DONE)) begin
            nxt = trig_mode ? S_ARMED : S_CAPT;
        end else if (last_rec) begin
            nxt = S_DONE;
        end else if (trig_hit) begin
            nxt = S_CAPT;
        end
    end

    // State register, free-running timestamp and per-session record count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur      <= S_IDLE;
            ts       <= '0;
            capt_cnt <= '0;
        end else begin
            cur <= nxt;
            ts  <= ts + TS_W'(1);
            if (clear || (arm && !abort && (cur == S_IDLE || cur == S_DONE)))
                capt_cnt <= '0;
            else if (store)
                capt_cnt <= capt_cnt + CLW'(1);
        end
    end

    // FIFO storage; contents are don't-care while the slot is not between the pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= record;
    end

    // FIFO pointers; clear discards everything queued.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Saturating per-fuse-type event counters and drop counter.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            drop_cnt <= '0;
            for (int i = 0; i < 4; i++)
                cnt[i] <= '0;
        end else begin
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + CNT_W'(1);
            for (int i = 0; i < 4; i++)
                if (count_en && trace_ftype == 2'(i) && cnt[i] != '1)
                    cnt[i] <= cnt[i] + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fusion_trace_buffer.sv
// Directed bench for fusion_trace_buffer: vector table for trigger/filter, hand sequences for capture, overflow, auto-stop.
// Expected records are queued by the bench with its own timestamp model and compared on every pop.
// Two instances share stimulus: default CAPT_LEN=64 and CAPT_LEN=8.
module tb_fusion_trace_buffer;
    localparam int PC_W  = 32;
    localparam int TS_W  = 16;
    localparam int CNT_W = 16;
    localparam int DW    = TS_W + PC_W + 35;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, trace_valid, trace_fuse, arm, trig_mode, fused_only, abort, clear, out_ready;
    logic [PC_W-1:0] trace_pc, trig_pc;
    logic [31:0] trace_instr;
    logic [1:0] trace_ftype;

    logic out_valid, out_valid8;
    logic [DW-1:0] out_data, out_data8;
    logic [4*CNT_W-1:0] fuse_cnt, fuse_cnt8;
    logic [CNT_W-1:0] drop_cnt, drop_cnt8;
    logic [1:0] state, state8;

    fusion_trace_buffer u_dut (
        .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_instr(trace_instr), .trace_fuse(trace_fuse), .trace_ftype(trace_ftype),
        .arm(arm), .trig_mode(trig_mode), .trig_pc(trig_pc), .fused_only(fused_only),
        .abort(abort), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .fuse_cnt(fuse_cnt), .drop_cnt(drop_cnt), .state(state)
    );

    fusion_trace_buffer #(.CAPT_LEN(8)) u_dut8 (
        .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_instr(trace_instr), .trace_fuse(trace_fuse), .trace_ftype(trace_ftype),
        .arm(arm), .trig_mode(trig_mode), .trig_pc(trig_pc), .fused_only(fused_only),
        .abort(abort), .clear(clear), .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .fuse_cnt(fuse_cnt8), .drop_cnt(drop_cnt8), .state(state8)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [TS_W-1:0] ts_model;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic        clr, arm, tmode, fonly, tv;
        logic [31:0] pc;
        logic [1:0]  ft;
        logic        st;
        logic [1:0]  exp_state;
        logic        exp_ov;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic quiet();
        arm = 0; abort = 0; clear = 0; trace_valid = 0;
        trace_fuse = 0; trace_ftype = 2'b00;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [1:0] ft, input logic fz);
        trace_valid = 1; trace_pc = pc; trace_instr = {pc[15:0], 16'h0013};
        trace_ftype = ft; trace_fuse = fz;
    endtask

    // One clock: check any pop on u_dut, then model the push/flush and the timestamp.
    task automatic step(input logic exp_store);
        logic [DW-1:0] r;
        if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop_unexpected: got %0h expected none", out_data);
            end else begin
                r = exp_q.pop_front();
                chk("pop_data", out_data, r);
            end
        end
        @(posedge clk);
        if (!rst || clear) exp_q.delete();
        else if (exp_store) exp_q.push_back({ts_model, trace_pc, trace_instr, trace_fuse, trace_ftype});
        ts_model = rst ? ts_model + 1'b1 : '0;
        #1;
    endtask

    initial begin
        quiet();
        rst = 0; out_ready = 0; trig_mode = 0; fused_only = 0;
        trig_pc = 32'h40; trace_pc = 0; trace_instr = 0; ts_model = 0;

        // Reset
        step(0); step(0);
        chk("rst_state", state, 2'b00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_fuse_cnt", fuse_cnt, '0);
        chk("rst_drop_cnt", drop_cnt, '0);
        chk("rst_state8", state8, 2'b00);
        rst = 1;
        step(0);

        // Trigger and filter vectors: clr arm tmode fonly tv pc ft st state ov
        vecs = '{
            '{1,0,0,0,0,32'h000,2'b00,0,2'b00,0},
            '{0,1,1,0,0,32'h000,2'b00,0,2'b01,0},
            '{0,0,0,0,1,32'h038,2'b00,0,2'b01,0},
            '{0,0,0,0,1,32'h03C,2'b00,0,2'b01,0},
            '{0,0,0,0,1,32'h040,2'b00,1,2'b10,1},
            '{0,0,0,0,1,32'h044,2'b00,1,2'b10,1},
            '{0,0,0,0,0,32'h000,2'b00,0,2'b10,0},
            '{1,0,0,0,0,32'h000,2'b00,0,2'b00,0},
            '{0,1,0,1,0,32'h000,2'b00,0,2'b10,0},
            '{0,0,0,1,1,32'h100,2'b00,0,2'b10,0},
            '{0,0,0,1,1,32'h104,2'b01,1,2'b10,1},
            '{0,0,0,1,1,32'h108,2'b11,1,2'b10,1},
            '{0,0,0,1,1,32'h10C,2'b00,0,2'b10,0},
            '{0,0,0,1,1,32'h110,2'b10,1,2'b10,1},
            '{0,0,0,1,0,32'h000,2'b00,0,2'b10,0}
        };
        out_ready = 1;
        pops = 0;
        foreach (vecs[i]) begin
            quiet();
            clear = vecs[i].clr; arm = vecs[i].arm; trig_mode = vecs[i].tmode;
            fused_only = vecs[i].fonly;
            if (vecs[i].tv) drive(vecs[i].pc, vecs[i].ft, vecs[i].ft != 2'b00);
            step(vecs[i].st);
            chk($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
        end
        chk("vec_pops", pops, 5);
        chk("filter_fuse_cnt", fuse_cnt, {16'd1, 16'd1, 16'd1, 16'd2});
        chk("filter_drop_cnt", drop_cnt, 16'd0);
        fused_only = 0;

        // Immediate capture, concurrent drain
        quiet(); clear = 1; step(0);
        quiet(); arm = 1; trig_mode = 0; step(0);
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            quiet(); drive(32'h200 + 4*i, 2'b01, 1'b1); step(1);
        end
        quiet(); step(0); step(0);
        chk("imm_pops", pops, 5);
        chk("imm_state", state, 2'b10);
        chk("imm_out_valid", out_valid, 1'b0);
        chk("imm_fuse_cnt01", fuse_cnt[2*CNT_W-1:CNT_W], 16'd5);

        // Overflow with drain stalled
        quiet(); clear = 1; step(0);
        out_ready = 0;
        quiet(); arm = 1; step(0);
        for (int i = 0; i < 20; i++) begin
            quiet(); drive(32'h300 + 4*i, 2'b11, 1'b1); step(i < 16);
        end
        quiet(); step(0);
        chk("ovf_out_valid", out_valid, 1'b1);
        chk("ovf_drop_cnt", drop_cnt, 16'd4);
        chk("ovf_fuse_cnt11", fuse_cnt[4*CNT_W-1:3*CNT_W], 16'd20);
        chk("ovf_state", state, 2'b10);
        pops = 0; out_ready = 1;
        repeat (18) step(0);
        chk("ovf_pops", pops, 16);
        chk("ovf_drained", out_valid, 1'b0);
        chk("ovf_q_empty", exp_q.size(), 0);

        // Auto-stop after 8 records on the CAPT_LEN=8 instance
        quiet(); clear = 1; step(0);
        quiet(); arm = 1; step(0);
        for (int i = 0; i < 10; i++) begin
            quiet(); drive(32'h400 + 4*i, 2'b10, 1'b1); step(1);
            if (i == 6) chk("auto_state8_7th", state8, 2'b10);
            if (i == 7) chk("auto_state8_8th", state8, 2'b11);
        end
        quiet(); step(0); step(0);
        chk("auto_state8_done", state8, 2'b11);
        chk("auto_fuse_cnt8", fuse_cnt8[3*CNT_W-1:2*CNT_W], 16'd8);
        chk("auto_state_long", state, 2'b10);

        // abort beats arm
        quiet(); abort = 1; arm = 1; step(0);
        chk("abort_arm_state", state, 2'b11);
        chk("abort_arm_state8", state8, 2'b11);

        // Re-arm from DONE: capture count restarts, FIFO kept
        out_ready = 0;
        quiet(); arm = 1; step(0);
        chk("rearm_state8", state8, 2'b10);
        for (int i = 0; i < 8; i++) begin
            quiet(); drive(32'h500 + 4*i, 2'b00, 1'b0); step(1);
            if (i == 6) chk("rearm_state8_7th", state8, 2'b10);
            if (i == 7) chk("rearm_state8_8th", state8, 2'b11);
        end
        quiet(); step(0);
        chk("rearm_out_valid8", out_valid8, 1'b1);

        // clear beats abort and arm; queued records discarded
        quiet(); clear = 1; abort = 1; arm = 1; step(0);
        chk("clr_state", state, 2'b00);
        chk("clr_state8", state8, 2'b00);
        chk("clr_out_valid", out_valid, 1'b0);
        chk("clr_out_valid8", out_valid8, 1'b0);
        chk("clr_fuse_cnt8", fuse_cnt8, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
